// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the main-memory port arbiter:
//   - arb_state_e : transaction sequencer states (IDLE, ISSUE, WAIT, RESP)
//   - GRANT_*     : owner codes driven on grant_o
//   - *_DEF       : default widths / timeout used by mem_port_arbiter
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned LINE_W_DEF  = 256;
  localparam int unsigned TIMEOUT_DEF = 63;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_rr_pick
// Combinational two-way round-robin picker for the memory port arbiter.
//   ic_req_i     in  I-cache request
//   dc_req_i     in  D-cache request
//   last_grant_i in  owner code of the most recent grant (GRANT_I / GRANT_D)
//   grant_o      out picked owner code (GRANT_NONE when nobody requests)
// A lone requester always wins; on a conflict the side that did not win last
// time is chosen, so neither cache can starve the other.
// -----------------------------------------------------------------------------
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic       ic_req_i,
  input  logic       dc_req_i,
  input  logic [1:0] last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = GRANT_NONE;
    if (ic_req_i && dc_req_i) begin
      grant_o = (last_grant_i == GRANT_D) ? GRANT_I : GRANT_D;
    end else if (ic_req_i) begin
      grant_o = GRANT_I;
    end else if (dc_req_i) begin
      grant_o = GRANT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single-ported main data memory between the I-cache refill path
// and the D-cache refill / write-back path. Each transaction is sequenced as
// IDLE (grant) -> ISSUE (one-cycle strobe) -> WAIT (for mem_ack_i) -> RESP
// (one-cycle ack to the owner), then back to IDLE.
//
// Ports
//   clk_i         in   clock, rising edge
//   rst_i         in   asynchronous reset, active-low
//   ic_req_i      in   I-cache refill request, held until ic_ack_o
//   ic_addr_i     in   I-cache line address
//   ic_ack_o      out  one-cycle completion pulse
//   ic_data_o     out  refill line, valid while ic_ack_o
//   dc_req_i      in   D-cache request, held until dc_ack_o
//   dc_write_i    in   1 = write-back, 0 = refill
//   dc_addr_i     in   D-cache line address
//   dc_wdata_i    in   write-back line
//   dc_ack_o      out  one-cycle completion pulse
//   dc_rdata_o    out  refill line, valid while dc_ack_o (zero for write-back)
//   mem_enable_o  out  memory strobe, one cycle per transaction
//   mem_write_o   out  memory write select
//   mem_addr_o    out  memory address
//   mem_data_o    out  memory write data
//   mem_ack_i     in   memory completion pulse
//   mem_data_i    in   memory read data, valid with mem_ack_i
//   grant_o       out  00 none, 01 I-cache, 10 D-cache
//   stall_o       out  pipeline stall (combinational)
//   err_o         out  sticky timeout error
//
// Optional feature macro: MEM_ARB_TIMEOUT_EN
//   Defined   : WAIT gives up after TIMEOUT cycles without mem_ack_i, acks the
//               owner with zero data and sets err_o (sticky until reset).
//   Undefined : WAIT persists until mem_ack_i; err_o is tied to 0.
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned LINE_W  = LINE_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_ack_o,
  output logic [LINE_W-1:0] ic_data_o,

  input  logic              dc_req_i,
  input  logic              dc_write_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [LINE_W-1:0] dc_wdata_i,
  output logic              dc_ack_o,
  output logic [LINE_W-1:0] dc_rdata_o,

  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i,

  output logic [1:0]        grant_o,
  output logic              stall_o,
  output logic              err_o
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // State and transaction registers
  // ---------------------------------------------------------------------------
  arb_state_e        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        last_q,  last_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              write_q, write_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic [1:0]        pick;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  mem_arb_rr_pick u_rr_pick (
    .ic_req_i     (ic_req_i),
    .dc_req_i     (dc_req_i),
    .last_grant_i (last_q),
    .grant_o      (pick)
  );

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif

    case (state_q)
      IDLE: begin
        // mem_ack_i is deliberately ignored here, so a stale ack from a
        // transaction abandoned by reset cannot complete anything.
        if (pick != GRANT_NONE) begin
          owner_d = pick;
          last_d  = pick;
          rdata_d = '0;
          state_d = ISSUE;
          if (pick == GRANT_I) begin
            addr_d  = ic_addr_i;
            write_d = 1'b0;
            wdata_d = '0;
          end else begin
            addr_d  = dc_addr_i;
            write_d = dc_write_i;
            wdata_d = dc_wdata_i;
          end
        end
      end

      ISSUE: begin
        if (mem_ack_i) begin
          rdata_d = write_q ? '0 : mem_data_i;
          state_d = RESP;
        end else begin
          state_d = WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      WAIT: begin
        if (mem_ack_i) begin
          rdata_d = write_q ? '0 : mem_data_i;
          state_d = RESP;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        // cnt_q counts completed WAIT cycles, so the last permitted one is
        // TIMEOUT-1; that cycle without an ack ends the wait.
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      owner_q <= GRANT_NONE;
      last_q  <= GRANT_I;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign grant_o      = (state_q == IDLE) ? GRANT_NONE : owner_q;
  assign mem_enable_o = (state_q == ISSUE);
  assign mem_write_o  = write_q;
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = wdata_q;

  assign ic_ack_o     = (state_q == RESP) && (owner_q == GRANT_I);
  assign dc_ack_o     = (state_q == RESP) && (owner_q == GRANT_D);
  assign ic_data_o    = ic_ack_o ? rdata_q : '0;
  assign dc_rdata_o   = dc_ack_o ? rdata_q : '0;

  // A requester still waiting while the other one is being acked keeps the
  // pipeline stalled.
  assign stall_o      = (ic_req_i & ~ic_ack_o) | (dc_req_i & ~dc_ack_o);

`ifdef MEM_ARB_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          ic_req_i = 1'b0;
  logic [AW-1:0] ic_addr_i = '0;
  logic          ic_ack_o;
  logic [LW-1:0] ic_data_o;
  logic          dc_req_i = 1'b0;
  logic          dc_write_i = 1'b0;
  logic [AW-1:0] dc_addr_i = '0;
  logic [LW-1:0] dc_wdata_i = '0;
  logic          dc_ack_o;
  logic [LW-1:0] dc_rdata_o;
  logic          mem_enable_o;
  logic          mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [LW-1:0] mem_data_o;
  logic          mem_ack_i;
  logic [LW-1:0] mem_data_i;
  logic [1:0]    grant_o;
  logic          stall_o;
  logic          err_o;

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(63)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_ack_o(ic_ack_o), .ic_data_o(ic_data_o),
    .dc_req_i(dc_req_i), .dc_write_i(dc_write_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
    .dc_ack_o(dc_ack_o), .dc_rdata_o(dc_rdata_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .grant_o(grant_o), .stall_o(stall_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the memory, and which phase of the transaction
  // the arbiter should be presenting (strobe cycle / response cycle).
  logic [1:0]      m_owner = 2'b00;
  logic [1:0]      m_last  = 2'b01;
  bit              m_issue = 1'b0;
  bit              m_resp  = 1'b0;
  bit              mon_en  = 1'b0;
  int              mem_mode = 0;   // 0 silent, 1 responsive memory, 3 ack every cycle
  logic [LW+1:0]   exp_q[$];       // {owner, expected line} per completed access

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Memory responder: acks 0..6 cycles after the strobe with random data and
  // records what the owner must receive. Occasionally acks while idle.
  // ---------------------------------------------------------------------------
  initial begin
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (mem_mode == 3) begin
        mem_ack_i  = 1'b1;
        mem_data_i = rand_line();
      end else if (mem_mode == 1) begin
        if (mem_enable_o) begin
          repeat ($urandom_range(0, 6)) @(negedge clk_i);
          mem_data_i = rand_line();
          mem_ack_i  = 1'b1;
          exp_q.push_back({m_owner, (m_owner == 2'b10 && dc_write_i) ? {LW{1'b0}} : mem_data_i});
        end else if (m_owner == 2'b00 && $urandom_range(0, 7) == 0) begin
          mem_ack_i  = 1'b1;
          mem_data_i = rand_line();
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: steps the reference model once per clock and compares.
  // ---------------------------------------------------------------------------
  initial begin
    logic          ic_r, dc_r, exp_ia, exp_da;
    logic [LW+1:0] e;
    forever begin
      @(posedge clk_i);
      #1;
      if (mon_en) begin
        ic_r = ic_req_i;
        dc_r = dc_req_i;
        if (m_owner == 2'b00) begin
          if (ic_r && dc_r)  m_owner = (m_last == 2'b01) ? 2'b10 : 2'b01;
          else if (ic_r)     m_owner = 2'b01;
          else if (dc_r)     m_owner = 2'b10;
          if (m_owner != 2'b00) begin
            m_last  = m_owner;
            m_issue = 1'b1;
          end
        end else if (m_resp) begin
          m_owner = 2'b00;
          m_resp  = 1'b0;
        end else begin
          m_issue = 1'b0;
          if (mem_ack_i) m_resp = 1'b1;
        end

        exp_ia = m_resp && (m_owner == 2'b01);
        exp_da = m_resp && (m_owner == 2'b10);
        chk("grant",      LW'(grant_o),      LW'(m_owner));
        chk("mem_enable", LW'(mem_enable_o), LW'(m_issue));
        chk("ic_ack",     LW'(ic_ack_o),     LW'(exp_ia));
        chk("dc_ack",     LW'(dc_ack_o),     LW'(exp_da));
        chk("stall",      LW'(stall_o),      LW'((ic_r & ~exp_ia) | (dc_r & ~exp_da)));
        chk("err",        LW'(err_o),        '0);

        if (m_owner != 2'b00 && !m_resp) begin
          chk("mem_addr",  LW'(mem_addr_o),  LW'((m_owner == 2'b01) ? ic_addr_i : dc_addr_i));
          chk("mem_write", LW'(mem_write_o), LW'((m_owner == 2'b10) & dc_write_i));
          if (m_owner == 2'b10 && dc_write_i) chk("mem_wdata", mem_data_o, dc_wdata_i);
        end

        if (m_resp) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL resp_unexpected actual=ack required=no_ack");
          end else begin
            e = exp_q.pop_front();
            chk("resp_data", (m_owner == 2'b01) ? ic_data_o : dc_rdata_o, e[LW-1:0]);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Requester agents
  // ---------------------------------------------------------------------------
  task automatic ic_agent(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      if (i != 0) repeat ($urandom_range(1, 3)) @(negedge clk_i);
      ic_addr_i = $urandom() & 32'hFFFF_FFE0;
      ic_req_i  = 1'b1;
      t = 0;
      do begin @(negedge clk_i); t++; end while (!ic_ack_o && t < 200);
      if (!ic_ack_o) chk("ic_ack_timeout", LW'(ic_ack_o), LW'(1));
      ic_req_i = 1'b0;
    end
  endtask

  task automatic dc_agent(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      if (i != 0) repeat ($urandom_range(1, 3)) @(negedge clk_i);
      dc_addr_i  = $urandom() & 32'hFFFF_FFE0;
      dc_write_i = 1'($urandom_range(0, 1));
      dc_wdata_i = ($urandom_range(0, 3) == 0) ? {LW{1'b1}} : rand_line();
      dc_req_i   = 1'b1;
      t = 0;
      do begin @(negedge clk_i); t++; end while (!dc_ack_o && t < 200);
      if (!dc_ack_o) chk("dc_ack_timeout", LW'(dc_ack_o), LW'(1));
      dc_req_i = 1'b0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"},  LW'(grant_o),      '0);
    chk({tag, "_enable"}, LW'(mem_enable_o), '0);
    chk({tag, "_write"},  LW'(mem_write_o),  '0);
    chk({tag, "_addr"},   LW'(mem_addr_o),   '0);
    chk({tag, "_wdata"},  mem_data_o,        '0);
    chk({tag, "_ic_ack"}, LW'(ic_ack_o),     '0);
    chk({tag, "_dc_ack"}, LW'(dc_ack_o),     '0);
    chk({tag, "_ic_dat"}, ic_data_o,         '0);
    chk({tag, "_dc_dat"}, dc_rdata_o,        '0);
    chk({tag, "_err"},    LW'(err_o),        '0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int seen;
    int enables;

    repeat (3) @(negedge clk_i);
    chk_all_zero("reset");
    chk("reset_stall", LW'(stall_o), '0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Random traffic; both agents raise their first request together, so the
    // first conflict after reset must go to the D-cache.
    mem_mode = 1;
    mon_en   = 1'b1;
    fork
      ic_agent(40);
      dc_agent(40);
    join
    repeat (3) @(negedge clk_i);
    chk("sb_drained", LW'(exp_q.size()), '0);
    mon_en   = 1'b0;
    mem_mode = 0;

    // Reset while waiting on memory, then a late memory ack.
    @(negedge clk_i);
    ic_addr_i = 32'h100;
    ic_req_i  = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("wait_grant", LW'(grant_o),    LW'(2'b01));
    chk("wait_addr",  LW'(mem_addr_o), LW'(32'h100));
    chk("wait_en",    LW'(mem_enable_o), '0);
    ic_req_i = 1'b0;
    rst_i    = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk_i);
    rst_i    = 1'b1;
    mem_mode = 3;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      if (ic_ack_o || dc_ack_o || grant_o != 2'b00 || mem_enable_o) seen++;
    end
    chk("postrst_quiet", LW'(seen), '0);
    mem_mode = 0;
    @(negedge clk_i);

    // Write-back with no memory response.
    dc_addr_i  = 32'h2A0;
    dc_write_i = 1'b1;
    dc_wdata_i = {LW{1'b1}};
    dc_req_i   = 1'b1;
    seen    = -1;
    enables = 0;
    for (int c = 1; c <= 210; c++) begin
      @(negedge clk_i);
      if (mem_enable_o) enables++;
      if (c > 1 && c < 60) begin
        if (mem_write_o !== 1'b1 || mem_data_o !== {LW{1'b1}} || mem_addr_o !== 32'h2A0)
          chk("noack_hold", {mem_write_o, mem_addr_o, mem_data_o[LW-AW-2:0]},
              {1'b1, 32'h2A0, {(LW-AW-1){1'b1}}});
      end
      if (dc_ack_o && seen < 0) begin
        seen = c;
        chk("noack_rdata", dc_rdata_o, '0);
        dc_req_i = 1'b0;
      end
    end
    chk("noack_enables", LW'(enables), LW'(1));
`ifdef MEM_ARB_TIMEOUT_EN
    chk("timeout_ack_cycle", LW'(seen), LW'(65));
    chk("timeout_err",       LW'(err_o), LW'(1));
`else
    chk("noack_no_ack", LW'(seen),     LW'(-1));
    chk("noack_grant",  LW'(grant_o),  LW'(2'b10));
    chk("noack_write",  LW'(mem_write_o), LW'(1));
    chk("noack_wdata",  mem_data_o,    {LW{1'b1}});
    chk("noack_stall",  LW'(stall_o),  LW'(1));
    chk("noack_err",    LW'(err_o),    '0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported main data memory between the instruction-cache refill path and the data-cache refill/write-back path of the pipelined RISC-V core.
- Sequences each memory transaction with a FSM: grant, issue, wait, respond.
- Produces the pipeline stall that feeds the Control/hazard units' Stall_i.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 256, cache-line width in bits
TIMEOUT, 63, max WAIT cycles before error (used only with MEM_ARB_TIMEOUT_EN)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
ic_req_i  in  1  I-cache refill request; held until ic_ack_o
ic_addr_i  in  ADDR_W  I-cache line address
ic_ack_o  out  1  one-cycle completion pulse
ic_data_o  out  LINE_W  refill line; valid while ic_ack_o=1
dc_req_i  in  1  D-cache request; held until dc_ack_o
dc_write_i  in  1  1=write-back, 0=refill
dc_addr_i  in  ADDR_W  D-cache line address
dc_wdata_i  in  LINE_W  write-back line
dc_ack_o  out  1  one-cycle completion pulse
dc_rdata_o  out  LINE_W  refill line; valid while dc_ack_o=1
mem_enable_o  out  1  memory strobe, one cycle per transaction
mem_write_o  out  1  memory write select
mem_addr_o  out  ADDR_W  memory address
mem_data_o  out  LINE_W  memory write data
mem_ack_i  in  1  memory completion pulse
mem_data_i  in  LINE_W  memory read data; valid with mem_ack_i
grant_o  out  2  00 none, 01 I-cache, 10 D-cache
stall_o  out  1  pipeline stall
err_o  out  1  sticky timeout error

Behaviour:
- Reset (rst_i=0, asynchronous): FSM=IDLE, last_grant=I. All outputs 0, including data and address registers. Reset mid-transaction abandons it; any later mem_ack_i is ignored because IDLE ignores it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Only one request: grant it.
  - Both requests: grant the requester opposite last_grant (round-robin). After reset, the first conflict goes to D.
  - On grant: latch owner, address, write flag and write data into registers; update last_grant; go to ISSUE.
- ISSUE:
  - mem_enable_o=1 for exactly this cycle.
  - mem_write_o/addr/data are driven from the latched registers and stay stable through WAIT.
  - mem_ack_i=1 in ISSUE goes straight to RESP; otherwise go to WAIT.
- WAIT: hold until mem_ack_i=1, capturing mem_data_i on that edge; then go to RESP.
- RESP:
  - Owner's ack_o=1 for one cycle, with registered line data (zero for write-back).
  - Return to IDLE.
  - The requester must drop req in this cycle; IDLE re-samples on the next cycle.
- Latency: req seen in IDLE at cycle t → mem_enable_o at t+1 → mem_ack_i at cycle k (k≥t+1) → ack_o at k+1. The minimum is 3 cycles from request to ack.
- grant_o: the owner code during ISSUE/WAIT/RESP; 00 in IDLE.
- stall_o (combinational) = (ic_req_i & ~ic_ack_o) | (dc_req_i & ~dc_ack_o). A second requester waiting during RESP keeps stall_o=1.
- Requester misbehaviour:
  - A request dropped before its ack does not abort the transaction; the ack pulse is still issued.
  - Requester inputs change after grant are ignored.
- mem_ack_i in IDLE or RESP is ignored.
- err_o is 0 unless the optional feature sets it.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - At TIMEOUT cycles without mem_ack_i, go to RESP with zero data and set err_o=1 (sticky until reset).
  - A late mem_ack_i is then ignored.
- Undefined: no counter; WAIT persists indefinitely; err_o is tied to 0. The port list is unchanged.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - grant codes GRANT_NONE=2'b00, GRANT_I=2'b01, GRANT_D=2'b10
  - default widths
- One natural sub-module, mem_arb_rr_pick: a combinational 2-way round-robin picker (req pair + last_grant → grant code).
- FSM, registers and timeout counter stay in the top module.

Test Plan:
- Reset then ic_req_i=1, addr=0x100; memory acks 10 cycles after enable → one mem_enable_o pulse with mem_addr_o=0x100 and mem_write_o=0; ic_ack_o pulses the cycle after mem_ack_i; ic_data_o=mem_data_i; stall_o=1 until the ack cycle.
- dc_req_i=1, dc_write_i=1, addr=0x2A0, wdata=all-ones → mem_write_o=1, mem_data_o=all-ones held through WAIT; dc_ack_o pulses with dc_rdata_o=0.
- ic_req_i and dc_req_i raised the same cycle after reset → D granted first (grant_o=10), then I (grant_o=01); stall_o stays 1 until the second ack.
- Two back-to-back simultaneous request pairs → grant order D, I, D, I (no starvation).
- rst_i pulsed low during WAIT, then mem_ack_i → all outputs 0, no ack issued, FSM in IDLE.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT=63 and no mem_ack_i → owner ack after 63 WAIT cycles with zero data; err_o=1 and stays 1; without the macro, the FSM is still in WAIT at 200 cycles and err_o=0.
